pc_updater: RTL and testbench

- Program-counter register and next-PC logic for the single-cycle RV32I core.
- Each rising clock edge loads the next PC, computed from the decoded instruction class `t`, the sign-extended immediate `imm` and the register/compare operand `r`.
- Drives instruction fetch (`pc`) and the link value for JAL/JALR writeback (`pc_plus4`).

---
 rtl/pc_updater.sv | 86 ++++++++
 tb/tb_pc_updater.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_updater.sv
// Program counter and next-PC selection for the single-cycle RV32I core.
// Optional macro PC_UPDATER_MISALIGN_TRAP_EN freezes pc on a misaligned target and raises a sticky trap.
module pc_updater #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  t,
    input  logic [31:0] imm,
    input  logic [31:0] r,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
`ifdef PC_UPDATER_MISALIGN_TRAP_EN
    output logic        trap,
`endif
    output logic        misaligned
);

    localparam logic [3:0] T_BRANCH = 4'd6;
    localparam logic [3:0] T_JALR   = 4'd7;
    localparam logic [3:0] T_JAL    = 4'd8;

    logic [31:0] pc_q, pc_d;
    logic [31:0] target;
    logic        taken;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

    // Only taken control transfers produce a target; everything else falls through to pc + 4.
    always_comb begin
        taken  = 1'b0;
        target = pc_q + 32'd4;
        case (t)
            T_BRANCH: begin
                if (r != 32'd0) begin
                    taken  = 1'b1;
                    target = pc_q + imm;
                end
            end
            T_JALR: begin
                taken  = 1'b1;
                target = (r + imm) & 32'hFFFF_FFFE;
            end
            T_JAL: begin
                taken  = 1'b1;
                target = pc_q + imm;
            end
            default: ;
        endcase
    end

    assign misaligned = taken && (target[1:0] != 2'b00);

`ifdef PC_UPDATER_MISALIGN_TRAP_EN
    logic trap_q, trap_d;

    assign trap = trap_q;

    always_comb begin
        trap_d = trap_q | misaligned;
        pc_d   = (trap_q || misaligned) ? pc_q : target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            trap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            trap_q <= trap_d;
        end
    end
`else
    assign pc_d = target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_updater.sv
// Directed table-driven bench for pc_updater, plus hand sequences for async reset and misalignment.
module tb_pc_updater;

    logic        clk;
    logic        rst_n;
    logic [3:0]  t;
    logic [31:0] imm;
    logic [31:0] r;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
`ifdef PC_UPDATER_MISALIGN_TRAP_EN
    logic        trap;
`endif

    int nvec;
    int nfail;

    pc_updater #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .t          (t),
        .imm        (imm),
        .r          (r),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
`ifdef PC_UPDATER_MISALIGN_TRAP_EN
        .trap       (trap),
`endif
        .misaligned (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  t;
        logic [31:0] imm;
        logic [31:0] r;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    localparam int NV = 21;
    vec_t vt[NV];

    function automatic vec_t mk(input logic [3:0] tt, input logic [31:0] ii, input logic [31:0] rr,
                                input logic [31:0] ep, input logic em);
        vec_t v;
        v.t = tt; v.imm = ii; v.r = rr; v.exp_pc = ep; v.exp_mis = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        rst_n = 1'b0;
        t     = 4'd0;
        imm   = 32'd0;
        r     = 32'd0;

        // Sequence runs continuously from pc = 0 after reset release.
        vt[0]  = mk(4'd7, 32'd15,          32'd9,           32'd24,          1'b0);
        vt[1]  = mk(4'd7, 32'd15,          32'd9,           32'd24,          1'b0);
        vt[2]  = mk(4'd7, 32'd0,           32'd0,           32'd0,           1'b0);
        vt[3]  = mk(4'd0, 32'd0,           32'd0,           32'd4,           1'b0);
        vt[4]  = mk(4'd1, 32'd0,           32'd0,           32'd8,           1'b0);
        vt[5]  = mk(4'd2, 32'd0,           32'd0,           32'd12,          1'b0);
        vt[6]  = mk(4'd3, 32'd0,           32'd0,           32'd16,          1'b0);
        vt[7]  = mk(4'd4, 32'd0,           32'd0,           32'd20,          1'b0);
        vt[8]  = mk(4'd5, 32'd0,           32'd0,           32'd24,          1'b0);
        vt[9]  = mk(4'd9, 32'd0,           32'd0,           32'd28,          1'b0);
        vt[10] = mk(4'd15, 32'd77,         32'd5,           32'd32,          1'b0);
        vt[11] = mk(4'd7, 32'd0,           32'd100,         32'd100,         1'b0);
        vt[12] = mk(4'd6, 32'hFFFF_FFF8,   32'd1,           32'd92,          1'b0);
        vt[13] = mk(4'd8, 32'd8,           32'd0,           32'd100,         1'b0);
        vt[14] = mk(4'd6, 32'hFFFF_FFF8,   32'd0,           32'd104,         1'b0);
        vt[15] = mk(4'd6, 32'd3,           32'd0,           32'd108,         1'b0);
        vt[16] = mk(4'd7, 32'd0,           32'd40,          32'd40,          1'b0);
        vt[17] = mk(4'd8, 32'h100,         32'd0,           32'h128,         1'b0);
        vt[18] = mk(4'd7, 32'd0,           32'h1001,        32'h1000,        1'b0);
        vt[19] = mk(4'd7, 32'd12,          32'hFFFF_FFF0,   32'hFFFF_FFFC,   1'b0);
        vt[20] = mk(4'd1, 32'd0,           32'd0,           32'd0,           1'b0);

        #1;
        check("reset_pc", pc, 32'd0);
        check("reset_pc_plus4", pc_plus4, 32'd4);
        @(posedge clk);
        #1;
        check("reset_hold_pc", pc, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            t     = vt[i].t;
            imm   = vt[i].imm;
            r     = vt[i].r;
            #1;
            check($sformatf("vec%0d_mis", i), {31'd0, misaligned}, {31'd0, vt[i].exp_mis});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pc", i), pc, vt[i].exp_pc);
            check($sformatf("vec%0d_pc_plus4", i), pc_plus4, vt[i].exp_pc + 32'd4);
        end

        // Async reset between edges discards the pending update.
        @(negedge clk);
        t = 4'd8; imm = 32'h40; r = 32'd0;
        @(posedge clk);
        #1;
        check("pre_reset_pc", pc, 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_pc", pc, 32'd0);
        check("async_reset_pc_plus4", pc_plus4, 32'd4);
        @(posedge clk);
        #1;
        check("reset_held_pc", pc, 32'd0);

        // Misaligned jal target from pc = 0.
        @(negedge clk);
        rst_n = 1'b1;
        t = 4'd8; imm = 32'd6; r = 32'd0;
        #1;
        check("mis_flag", {31'd0, misaligned}, 32'd1);
        @(posedge clk);
        #1;
`ifdef PC_UPDATER_MISALIGN_TRAP_EN
        check("mis_trap_pc", pc, 32'd0);
        check("mis_trap", {31'd0, trap}, 32'd1);
        @(negedge clk);
        t = 4'd0; imm = 32'd0;
        @(posedge clk);
        #1;
        check("trap_frozen_pc", pc, 32'd0);
        check("trap_sticky", {31'd0, trap}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("trap_cleared", {31'd0, trap}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_trap_pc", pc, 32'd4);
`else
        check("mis_load_pc", pc, 32'd6);
        @(negedge clk);
        t = 4'd0; imm = 32'd0;
        @(posedge clk);
        #1;
        check("mis_then_seq_pc", pc, 32'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
